// File: rtl/control_unit.sv
// control_unit -- multicycle sequencer for the K-and-S datapath.
//
// Also carries k_and_s_pkg, which defines the decoded opcode type shared
// with the datapath.
//
// Ports:
//   clk                 clock; all state changes on the rising edge
//   rst_n               asynchronous active-low reset
//   decoded_instruction current opcode from the datapath decoder
//   zero_op, neg_op     registered datapath flags used by the conditional branches
//   unsigned_overflow,
//   signed_overflow     registered flags; accepted but not used for control
//   branch, pc_enable, ir_enable, addr_sel, c_sel,
//   write_reg_enable, flags_reg_enable
//                       datapath controls
//   operation           ALU select: 00 OR, 01 ADD, 10 SUB, 11 AND
//   ram_write_enable    RAM write strobe
//   halt                processor stopped
//   instr_count         retired-instruction counter; wraps to 0 after all ones

package k_and_s_pkg;
   typedef enum logic [3:0] {
      I_NOP    = 4'd0,
      I_LOAD   = 4'd1,
      I_STORE  = 4'd2,
      I_MOVE   = 4'd3,
      I_ADD    = 4'd4,
      I_SUB    = 4'd5,
      I_AND    = 4'd6,
      I_OR     = 4'd7,
      I_BRANCH = 4'd8,
      I_BZERO  = 4'd9,
      I_BNZERO = 4'd10,
      I_BNEG   = 4'd11,
      I_BNNEG  = 4'd12,
      I_HALT   = 4'd13
   } decoded_instruction_type;
endpackage

// state     | meaning
// RST_ST    | idle after reset; all outputs 0
// FETCH     | load IR from RAM at PC
// DECODE    | opcode settles; choose EXEC, LOAD_WAIT or HALT_ST
// EXEC      | execute ALU/move/store/branch; advance PC
// LOAD_WAIT | RAM read-latency cycle for a load
// LOAD_WB   | write RAM data into the register file; advance PC
// HALT_ST   | stopped until reset
module control_unit
   import k_and_s_pkg::*;
#(
   parameter int CNT_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  decoded_instruction_type decoded_instruction,
   input  logic                    zero_op,
   input  logic                    neg_op,
   input  logic                    unsigned_overflow,
   input  logic                    signed_overflow,
   output logic                    branch,
   output logic                    pc_enable,
   output logic                    ir_enable,
   output logic                    addr_sel,
   output logic                    c_sel,
   output logic                    write_reg_enable,
   output logic                    flags_reg_enable,
   output logic [1:0]              operation,
   output logic                    ram_write_enable,
   output logic                    halt,
   output logic [CNT_WIDTH-1:0]    instr_count
);

   typedef enum logic [2:0] {
      RST_ST    = 3'd0,
      FETCH     = 3'd1,
      DECODE    = 3'd2,
      EXEC      = 3'd3,
      LOAD_WAIT = 3'd4,
      LOAD_WB   = 3'd5,
      HALT_ST   = 3'd6
   } state_t;

   state_t state;

   // Overflow flags are reported to software elsewhere; nothing here branches on them.
   logic unused_flags;
   assign unused_flags = unsigned_overflow ^ signed_overflow;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RST_ST;
         instr_count <= '0;
      end else begin
         case (state)
            RST_ST:    state <= FETCH;
            FETCH:     state <= DECODE;
            DECODE: begin
               if (decoded_instruction == I_HALT)
                  state <= HALT_ST;
               else if (decoded_instruction == I_LOAD)
                  state <= LOAD_WAIT;
               else
                  state <= EXEC;
            end
            EXEC: begin
               state       <= FETCH;
               instr_count <= instr_count + CNT_WIDTH'(1);
            end
            LOAD_WAIT: state <= LOAD_WB;
            LOAD_WB: begin
               state       <= FETCH;
               instr_count <= instr_count + CNT_WIDTH'(1);
            end
            HALT_ST:   state <= HALT_ST;
            default:   state <= RST_ST;
         endcase
      end
   end

   // Outputs decode from the registered state so reset clears them without a
   // clock; only branch sees the flags, and only in EXEC.
   always_comb begin
      branch           = 1'b0;
      pc_enable        = 1'b0;
      ir_enable        = 1'b0;
      addr_sel         = 1'b0;
      c_sel            = 1'b0;
      write_reg_enable = 1'b0;
      flags_reg_enable = 1'b0;
      operation        = 2'b00;
      ram_write_enable = 1'b0;
      halt             = 1'b0;
      case (state)
         FETCH: begin
            addr_sel  = 1'b1;
            ir_enable = 1'b1;
         end
         EXEC: begin
            pc_enable = 1'b1;
            case (decoded_instruction)
               I_ADD, I_SUB, I_AND, I_OR: begin
                  write_reg_enable = 1'b1;
                  flags_reg_enable = 1'b1;
                  case (decoded_instruction)
                     I_ADD:   operation = 2'b01;
                     I_SUB:   operation = 2'b10;
                     I_AND:   operation = 2'b11;
                     default: operation = 2'b00;
                  endcase
               end
               I_MOVE:   write_reg_enable = 1'b1;
               I_STORE:  ram_write_enable = 1'b1;
               I_BRANCH: branch = 1'b1;
               I_BZERO:  branch = zero_op;
               I_BNZERO: branch = !zero_op;
               I_BNEG:   branch = neg_op;
               I_BNNEG:  branch = !neg_op;
               default:  ;
            endcase
         end
         LOAD_WB: begin
            c_sel            = 1'b1;
            write_reg_enable = 1'b1;
            pc_enable        = 1'b1;
         end
         HALT_ST: halt = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;
   import k_and_s_pkg::*;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   decoded_instruction_type decoded_instruction = I_NOP;
   logic zero_op = 1'b0, neg_op = 1'b0;
   logic unsigned_overflow = 1'b0, signed_overflow = 1'b0;
   logic branch, pc_enable, ir_enable, addr_sel, c_sel;
   logic write_reg_enable, flags_reg_enable, ram_write_enable, halt;
   logic [1:0] operation;
   logic [W-1:0] instr_count;

   int tests = 0;
   int fails = 0;
   int count_model = 0;

   control_unit #(.CNT_WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .decoded_instruction(decoded_instruction),
      .zero_op(zero_op), .neg_op(neg_op),
      .unsigned_overflow(unsigned_overflow), .signed_overflow(signed_overflow),
      .branch(branch), .pc_enable(pc_enable), .ir_enable(ir_enable),
      .addr_sel(addr_sel), .c_sel(c_sel), .write_reg_enable(write_reg_enable),
      .flags_reg_enable(flags_reg_enable), .operation(operation),
      .ram_write_enable(ram_write_enable), .halt(halt), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation got timeout, want finish");
      $fatal(1, "watchdog");
   end

   // Output vector: {branch,pc,ir,addr_sel,c_sel,wr,flags,op[1:0],ram_we,halt}
   function automatic logic [10:0] outs_now();
      return {branch, pc_enable, ir_enable, addr_sel, c_sel, write_reg_enable,
              flags_reg_enable, operation, ram_write_enable, halt};
   endfunction

   function automatic logic [10:0] mk(logic br, logic pc, logic ir, logic as,
                                      logic cs, logic wr, logic fl,
                                      logic [1:0] op, logic rw, logic h);
      return {br, pc, ir, as, cs, wr, fl, op, rw, h};
   endfunction

   // Reference: what the EXEC cycle should present for each opcode.
   function automatic logic [10:0] exp_exec(decoded_instruction_type i, logic z, logic n);
      case (i)
         I_ADD:    return mk(0, 1, 0, 0, 0, 1, 1, 2'b01, 0, 0);
         I_SUB:    return mk(0, 1, 0, 0, 0, 1, 1, 2'b10, 0, 0);
         I_AND:    return mk(0, 1, 0, 0, 0, 1, 1, 2'b11, 0, 0);
         I_OR:     return mk(0, 1, 0, 0, 0, 1, 1, 2'b00, 0, 0);
         I_MOVE:   return mk(0, 1, 0, 0, 0, 1, 0, 2'b00, 0, 0);
         I_STORE:  return mk(0, 1, 0, 0, 0, 0, 0, 2'b00, 1, 0);
         I_BRANCH: return mk(1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
         I_BZERO:  return mk(z, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
         I_BNZERO: return mk(!z, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
         I_BNEG:   return mk(n, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
         I_BNNEG:  return mk(!n, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
         default:  return mk(0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      endcase
   endfunction

   localparam logic [10:0] FETCH_V = 11'b001_1000_0000;
   localparam logic [10:0] HALT_V  = 11'b000_0000_0001;
   localparam logic [10:0] WB_V    = 11'b010_0110_0000;

   // Reset and leave the bench 1 time unit after the negedge where the DUT is in FETCH.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      tests++;
      if (outs_now() !== 11'b0 || instr_count !== '0) begin
         fails++;
         $display("FAIL reset_async: outs got %b want 0, count got %0d want 0", outs_now(), instr_count);
      end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      #1;
      tests++;
      if (outs_now() !== 11'b0) begin
         fails++;
         $display("FAIL rst_st_outs: got %b want 0", outs_now());
      end
      @(negedge clk); #1;
      count_model = 0;
   endtask

   // Runs one instruction starting in FETCH; ends in the next FETCH (or HALT_ST).
   task automatic run_instr(decoded_instruction_type i, logic z, logic n, string nm);
      int pcs = 0, rws = 0;
      logic [10:0] o;
      decoded_instruction = i;
      tests++;
      if (outs_now() !== FETCH_V) begin
         fails++;
         $display("FAIL %s fetch: got %b want %b", nm, outs_now(), FETCH_V);
      end
      @(negedge clk); #1;
      zero_op = !z; neg_op = !n;
      tests++;
      if (outs_now() !== 11'b0) begin
         fails++;
         $display("FAIL %s decode: got %b want 0", nm, outs_now());
      end
      @(negedge clk); #1;
      if (i == I_HALT) begin
         tests++;
         if (outs_now() !== HALT_V || instr_count !== W'(count_model)) begin
            fails++;
            $display("FAIL %s halt_entry: got %b cnt %0d want %b cnt %0d", nm, outs_now(), instr_count, HALT_V, count_model);
         end
         return;
      end
      if (i == I_LOAD) begin
         tests++;
         if (outs_now() !== 11'b0) begin
            fails++;
            $display("FAIL %s load_wait: got %b want 0", nm, outs_now());
         end
         @(negedge clk); #1;
         o = outs_now();
         pcs += int'(pc_enable); rws += int'(ram_write_enable);
         tests++;
         if (o !== WB_V) begin
            fails++;
            $display("FAIL %s load_wb: got %b want %b", nm, o, WB_V);
         end
      end else begin
         zero_op = z; neg_op = n;
         #1;
         o = outs_now();
         pcs += int'(pc_enable); rws += int'(ram_write_enable);
         tests++;
         if (o !== exp_exec(i, z, n)) begin
            fails++;
            $display("FAIL %s exec: got %b want %b", nm, o, exp_exec(i, z, n));
         end
         if (write_reg_enable && ram_write_enable) begin
            fails++;
            $display("FAIL %s wr_and_rw: got both high want exclusive", nm);
         end
      end
      @(negedge clk); #1;
      count_model = (count_model + 1) % (1 << W);
      tests++;
      if (instr_count !== W'(count_model) || ir_enable !== 1'b1 || pcs != 1 ||
          rws != ((i == I_STORE) ? 1 : 0)) begin
         fails++;
         $display("FAIL %s retire: cnt got %0d want %0d, ir got %b want 1, pc pulses %0d want 1, ram_we pulses %0d", nm, instr_count, count_model, ir_enable, pcs, rws);
      end
   endtask

   task automatic test_reset();
      do_reset();
      tests++;
      if (outs_now() !== FETCH_V || instr_count !== '0) begin
         fails++;
         $display("FAIL first_fetch: got %b cnt %0d want %b cnt 0", outs_now(), instr_count, FETCH_V);
      end
   endtask

   task automatic test_add();
      run_instr(I_ADD, 1'b0, 1'b0, "add");
      tests++;
      if (instr_count !== W'(1)) begin
         fails++;
         $display("FAIL add_count: got %0d want 1", instr_count);
      end
   endtask

   task automatic test_load();
      run_instr(I_LOAD, 1'b0, 1'b0, "load");
      run_instr(I_LOAD, 1'b1, 1'b1, "load2");
   endtask

   task automatic test_bzero();
      run_instr(I_BZERO, 1'b1, 1'b0, "bzero_taken");
      run_instr(I_BZERO, 1'b0, 1'b0, "bzero_not");
   endtask

   task automatic test_store();
      run_instr(I_STORE, 1'b0, 1'b0, "store");
   endtask

   task automatic test_random();
      for (int k = 0; k < 80; k++) begin
         int r;
         decoded_instruction_type i;
         r = $urandom_range(0, 15);
         if (r == 13) r = 0;
         i = decoded_instruction_type'(4'(r));
         run_instr(i, 1'($urandom), 1'($urandom), "random");
      end
   endtask

   task automatic test_reset_mid();
      decoded_instruction = I_ADD;
      @(negedge clk); #1;
      @(negedge clk); #1;
      zero_op = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      tests++;
      if (outs_now() !== 11'b0 || instr_count !== '0) begin
         fails++;
         $display("FAIL reset_in_exec: got %b cnt %0d want 0 cnt 0", outs_now(), instr_count);
      end
      do_reset();
      decoded_instruction = I_LOAD;
      @(negedge clk); #1;
      @(negedge clk); #1;
      #1;
      rst_n = 1'b0;
      @(negedge clk); #1;
      tests++;
      if (outs_now() !== 11'b0 || instr_count !== '0) begin
         fails++;
         $display("FAIL reset_in_load_wait: got %b cnt %0d want 0 cnt 0", outs_now(), instr_count);
      end
      do_reset();
   endtask

   task automatic test_halt();
      int bad = 0;
      run_instr(I_NOP, 1'b0, 1'b0, "pre_halt");
      run_instr(I_HALT, 1'b0, 1'b0, "halt");
      for (int k = 0; k < 22; k++) begin
         decoded_instruction = decoded_instruction_type'(4'($urandom_range(0, 12)));
         @(negedge clk); #1;
         if (outs_now() !== HALT_V || instr_count !== W'(count_model)) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL halt_hold: %0d bad cycles, want 0 (last %b cnt %0d)", bad, outs_now(), instr_count);
      end
      rst_n = 1'b0;
      #1;
      tests++;
      if (halt !== 1'b0 || instr_count !== '0) begin
         fails++;
         $display("FAIL halt_reset: halt %b cnt %0d want 0 and 0", halt, instr_count);
      end
      do_reset();
   endtask

   task automatic test_wrap();
      for (int k = 0; k < (1 << W) - 1; k++) run_instr(I_NOP, 1'b0, 1'b0, "wrap_fill");
      tests++;
      if (instr_count !== {W{1'b1}}) begin
         fails++;
         $display("FAIL wrap_full: got %0h want %0h", instr_count, {W{1'b1}});
      end
      run_instr(I_NOP, 1'b0, 1'b0, "wrap_last");
      tests++;
      if (instr_count !== '0) begin
         fails++;
         $display("FAIL wrap_zero: got %0h want 0", instr_count);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_load();
      test_bzero();
      test_store();
      test_random();
      test_reset_mid();
      test_halt();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
